pma_region_lookup: RTL
======================

// Module: pma_region_lookup
// PURPOSE
//  Runtime-programmable PMA lookup: generalises the static per-config region checks to a
//  writable, lockable rule table serving NrPorts independent lookup channels
//  (e.g. frontend fetch and LSU) through a registered one-cycle valid/ready pipeline.
//  Returns an attribute set per address plus saturating per-port miss counters.
// PARAMETERS
//  NrRules     16      rule table depth, 1..16 (<= config_pkg::NrMaxRules)
//  NrPorts     2       independent lookup channels, >= 1
//  AddrWidth   64      address, base and length width
//  DefaultAttr '0      pma_attr_t returned on miss
//  CntWidth    16      per-port miss counter width
// PORTS
//  clk_i         in   1                    clock
//  rst_i         in   1                    async reset, active-high
//  cfg_we_i      in   1                    table write strobe
//  cfg_idx_i     in   $clog2(NrRules)      rule index
//  cfg_base_i    in   AddrWidth            region base
//  cfg_len_i     in   AddrWidth            region length in bytes; 0 disables rule
//  cfg_attr_i    in   $bits(pma_attr_t)    region attributes
//  cfg_lock_i    in   1                    lock entry after this write
//  cfg_err_o     out  1                    1-cycle pulse: write hit locked entry or idx>=NrRules
//  req_valid_i   in   NrPorts              lookup request valid
//  req_ready_o   out  NrPorts              lookup request ready
//  req_addr_i    in   NrPorts x AddrWidth  lookup address
//  rsp_valid_o   out  NrPorts              response valid
//  rsp_ready_i   in   NrPorts              response ready
//  rsp_attr_o    out  NrPorts x pma_attr_t matched attributes
//  rsp_miss_o    out  NrPorts              no rule matched
//  rsp_idx_o     out  NrPorts x $clog2(NrRules) winning rule index, 0 on miss
//  miss_cnt_o    out  NrPorts x CntWidth   saturating miss counter
// BEHAVIOUR
//  Reset: every table entry base=0, len=0, attr=0, unlocked; all outputs 0; counters 0.
//  Match rule k: len_k!=0 && addr>=base_k && {1'b0,addr} < {1'b0,base_k}+{1'b0,len_k},
//   computed at AddrWidth+1 bits. No wrap: a region reaching past 2^AddrWidth matches up to top only.
//  Priority: lowest matching index wins. No match -> attr=DefaultAttr, miss=1, idx=0.
//  Pipeline, per port and independent: req_ready_o = !rsp_valid_o || rsp_ready_i.
//   A request fires on req_valid_i && req_ready_o. Response regs load on the next edge (latency 1).
//   rsp_valid_o clears on rsp_ready_i with no new fire. Under stall, rsp_* stay stable.
//   Back-to-back fires give one response per cycle.
//  Table write: takes effect at the edge where cfg_we_i=1.
//   A lookup firing in the same cycle sees the OLD table. Responses already registered are unchanged.
//  Lock: an entry written with cfg_lock_i=1 becomes read-only until reset.
//   A write to a locked entry, or with idx>=NrRules, changes nothing and pulses cfg_err_o next cycle.
//   The write carrying lock=1 itself succeeds.
//  Miss counter: increments when a miss response is loaded; saturates at all-ones, never wraps.
//  Reset mid-operation: in-flight responses dropped, rsp_valid_o=0, table and locks cleared.
// STRUCTURE
//  config_pkg additions:
//   - typedef struct packed {exec, cached, idempotent, shared} pma_attr_t
//   - typedef pma_rule_t {base, len, attr}
//   - reuse range_check semantics at parametrised width
//  Sub-module pma_match_encode (combinational, one instance per port):
//   - inputs: table and address
//   - outputs: hit, idx, attr via lowest-index priority encoder
//  Top holds table/lock flops, per-port response regs and counters.
// TESTING
//  1. Rule0 base=0x8000_0000 len=0x1000 attr=cached|exec; lookup 0x8000_0FFF -> hit idx0 cached|exec.
//     Lookup 0x8000_1000 -> miss, DefaultAttr, miss_cnt=1.
//  2. Overlap: rule3 base=0x1000 len=0x100 idempotent, rule1 base=0x1000 len=0x1000 exec;
//     lookup 0x1080 -> idx1 exec.
//  3. Lock: write rule2 with lock=1, then rewrite rule2 -> cfg_err_o pulses 1 cycle, lookups keep old attrs.
//  4. Same-cycle write rule0 and port0 fire at 0x10 (old len=0) -> miss.
//     Next fire after the write -> hit.
//  5. Backpressure: port1 rsp_ready_i=0 for 5 cycles with req_valid_i=1 -> req_ready_o=0, rsp stable.
//     Release -> in-order responses; port0 unaffected.
//  6. CntWidth=4: 20 misses -> miss_cnt=15. Assert rst_i mid-stream -> rsp_valid_o=0, table cleared.

Source files
------------

// File: rtl/pma_region_lookup_pkg.sv
// Shared types for the runtime-programmable PMA rule table.
// Attributes, rule layout and the overflow-safe region range check.
package pma_region_lookup_pkg;

    localparam int unsigned NrMaxRules   = 16;
    localparam int unsigned MaxAddrWidth = 64;

    typedef struct packed {
        logic exec;
        logic cached;
        logic idempotent;
        logic shared;
    } pma_attr_t;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] base;
        logic [MaxAddrWidth-1:0] len;
        pma_attr_t               attr;
    } pma_rule_t;

    // The end address is formed one bit wider so a region running past the
    // top of the address space clips there instead of wrapping to zero.
    function automatic logic range_check(
        input logic [MaxAddrWidth-1:0] addr,
        input logic [MaxAddrWidth-1:0] base,
        input logic [MaxAddrWidth-1:0] len
    );
        logic [MaxAddrWidth:0] top;
        top = {1'b0, base} + {1'b0, len};
        return (len != '0) && (addr >= base) && ({1'b0, addr} < top);
    endfunction

endpackage

// File: rtl/pma_region_lookup_match.sv
// Combinational rule matcher for one lookup channel.
// Lowest-index matching rule wins.
module pma_match_encode
    import pma_region_lookup_pkg::*;
#(
    parameter int unsigned NrRules   = 16,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  pma_rule_t             rules_i [NrRules],
    input  logic [AddrWidth-1:0]  addr_i,
    output logic                  hit_o,
    output logic [IdxWidth-1:0]   idx_o,
    output pma_attr_t             attr_o
);

    logic [NrRules-1:0] match;

    always_comb begin
        match = '0;
        for (int k = 0; k < int'(NrRules); k++) begin
            match[k] = range_check(MaxAddrWidth'(addr_i),
                                   rules_i[k].base,
                                   rules_i[k].len);
        end
    end

    // Scan downwards so the last assignment is the lowest matching index.
    always_comb begin
        hit_o  = |match;
        idx_o  = '0;
        attr_o = '0;
        for (int k = int'(NrRules) - 1; k >= 0; k--) begin
            if (match[k]) begin
                idx_o  = IdxWidth'(k);
                attr_o = rules_i[k].attr;
            end
        end
    end

endmodule

// File: rtl/pma_region_lookup.sv
// Writable, lockable PMA rule table serving NrPorts independent
// lookup channels through a registered one-deep valid/ready stage.
module pma_region_lookup
    import pma_region_lookup_pkg::*;
#(
    parameter int unsigned NrRules     = 16,
    parameter int unsigned NrPorts     = 2,
    parameter int unsigned AddrWidth   = 64,
    parameter pma_attr_t   DefaultAttr = '0,
    parameter int unsigned CntWidth    = 16,
    localparam int unsigned IdxWidth   = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cfg_we_i,
    input  logic [IdxWidth-1:0]                cfg_idx_i,
    input  logic [AddrWidth-1:0]               cfg_base_i,
    input  logic [AddrWidth-1:0]               cfg_len_i,
    input  pma_attr_t                          cfg_attr_i,
    input  logic                               cfg_lock_i,
    output logic                               cfg_err_o,
    input  logic [NrPorts-1:0]                 req_valid_i,
    output logic [NrPorts-1:0]                 req_ready_o,
    input  logic [NrPorts-1:0][AddrWidth-1:0]  req_addr_i,
    output logic [NrPorts-1:0]                 rsp_valid_o,
    input  logic [NrPorts-1:0]                 rsp_ready_i,
    output pma_attr_t [NrPorts-1:0]            rsp_attr_o,
    output logic [NrPorts-1:0]                 rsp_miss_o,
    output logic [NrPorts-1:0][IdxWidth-1:0]   rsp_idx_o,
    output logic [NrPorts-1:0][CntWidth-1:0]   miss_cnt_o
);

    if (NrRules < 1 || NrRules > NrMaxRules) begin : g_bad_depth
        $error("pma_region_lookup: NrRules out of range");
    end

    pma_rule_t          rules_q [NrRules];
    pma_rule_t          rules_d [NrRules];
    logic [NrRules-1:0] locked_q, locked_d;
    logic               cfg_err_q, cfg_err_d;
    logic               idx_ok, idx_locked;

    always_comb begin
        idx_ok     = (32'(cfg_idx_i) < NrRules);
        idx_locked = idx_ok && locked_q[cfg_idx_i];
    end

    always_comb begin
        rules_d   = rules_q;
        locked_d  = locked_q;
        cfg_err_d = 1'b0;
        if (cfg_we_i) begin
            if (!idx_ok || idx_locked) begin
                cfg_err_d = 1'b1;
            end else begin
                rules_d[cfg_idx_i].base = MaxAddrWidth'(cfg_base_i);
                rules_d[cfg_idx_i].len  = MaxAddrWidth'(cfg_len_i);
                rules_d[cfg_idx_i].attr = cfg_attr_i;
                locked_d[cfg_idx_i]     = cfg_lock_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rules_q   <= '{default: '0};
            locked_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            rules_q   <= rules_d;
            locked_q  <= locked_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err_o = cfg_err_q;

    // Lookups read the registered table, so a same-cycle write is not seen.
    logic [NrPorts-1:0]               hit;
    logic [NrPorts-1:0][IdxWidth-1:0] hit_idx;
    pma_attr_t [NrPorts-1:0]          hit_attr;

    for (genvar p = 0; p < int'(NrPorts); p++) begin : g_port
        pma_match_encode #(
            .NrRules   (NrRules),
            .AddrWidth (AddrWidth),
            .IdxWidth  (IdxWidth)
        ) u_match (
            .rules_i (rules_q),
            .addr_i  (req_addr_i[p]),
            .hit_o   (hit[p]),
            .idx_o   (hit_idx[p]),
            .attr_o  (hit_attr[p])
        );
    end

    logic [NrPorts-1:0]               rsp_valid_q, rsp_valid_d;
    pma_attr_t [NrPorts-1:0]          rsp_attr_q, rsp_attr_d;
    logic [NrPorts-1:0]               rsp_miss_q, rsp_miss_d;
    logic [NrPorts-1:0][IdxWidth-1:0] rsp_idx_q, rsp_idx_d;
    logic [NrPorts-1:0][CntWidth-1:0] miss_cnt_q, miss_cnt_d;
    logic [NrPorts-1:0]               req_fire;

    assign req_ready_o = ~rsp_valid_q | rsp_ready_i;
    assign req_fire    = req_valid_i & req_ready_o;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_attr_d  = rsp_attr_q;
        rsp_miss_d  = rsp_miss_q;
        rsp_idx_d   = rsp_idx_q;
        miss_cnt_d  = miss_cnt_q;
        for (int p = 0; p < int'(NrPorts); p++) begin
            if (req_fire[p]) begin
                rsp_valid_d[p] = 1'b1;
                rsp_miss_d[p]  = !hit[p];
                rsp_attr_d[p]  = hit[p] ? hit_attr[p] : DefaultAttr;
                rsp_idx_d[p]   = hit[p] ? hit_idx[p] : '0;
                if (!hit[p] && (miss_cnt_q[p] != '1)) begin
                    miss_cnt_d[p] = miss_cnt_q[p] + CntWidth'(1);
                end
            end else if (rsp_ready_i[p]) begin
                rsp_valid_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= '0;
            rsp_attr_q  <= '0;
            rsp_miss_q  <= '0;
            rsp_idx_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_attr_q  <= rsp_attr_d;
            rsp_miss_q  <= rsp_miss_d;
            rsp_idx_q   <= rsp_idx_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_attr_o  = rsp_attr_q;
    assign rsp_miss_o  = rsp_miss_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign miss_cnt_o  = miss_cnt_q;

endmodule
